// File: rtl/hdmi_if_pkg.sv
// Shared types and defaults for the HDMI block buffer scheduler.
//   sched_state_t : scheduler FSM states
//   BLK_LEN_DEF   : default words per block (64 px / 2 px per word)
//   PREFILL_DEF   : default complete blocks buffered before a frame starts reading
package hdmi_if_pkg;

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DROP} sched_state_t;

   localparam int unsigned BLK_LEN_DEF = 32;
   localparam int unsigned PREFILL_DEF = 16;

endpackage

// File: rtl/blk_framing_chk.sv
// Input-side block framing tracker and error detector.
// Tracks whether a block is open on the write side and how many words it has,
// and flags an illegal word among those offered in FILL/STREAM.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   chk_i         : a word is offered for writing in FILL/STREAM (error check enable)
//   wr_i          : the word is written into the FIFO (tracking update)
//   sob_i, eob_i  : start / end of block flags of the current word
//   err_o         : framing error on the current word (combinational)
module blk_framing_chk
   import hdmi_if_pkg::*;
#(
   parameter int unsigned BLK_LEN = BLK_LEN_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic chk_i,
   input  logic wr_i,
   input  logic sob_i,
   input  logic eob_i,
   output logic err_o
);

   localparam int unsigned   CW  = $clog2(BLK_LEN + 1);
   localparam logic [CW-1:0] LEN = CW'(BLK_LEN);

   logic          wr_mid_q, wr_mid_d;
   logic [CW-1:0] words_q, words_d, words_nxt;
   logic          in_blk;

   always_comb begin
      in_blk    = sob_i | wr_mid_q;
      words_nxt = sob_i ? CW'(1) : words_q + CW'(1);
      err_o     = chk_i & ((sob_i & wr_mid_q) |
                           (eob_i & ~in_blk) |
                           (~eob_i & in_blk & (words_nxt == LEN)));

      wr_mid_d = wr_mid_q;
      words_d  = words_q;
      // An erroneous word is not written; the next frame restarts from a clean state.
      if (err_o) begin
         wr_mid_d = 1'b0;
         words_d  = '0;
      end else if (wr_i & in_blk) begin
         wr_mid_d = ~eob_i;
         words_d  = eob_i ? '0 : words_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_mid_q <= 1'b0;
         words_q  <= '0;
      end else begin
         wr_mid_q <= wr_mid_d;
         words_q  <= words_d;
      end
   end

endmodule

// File: rtl/blocks_buf_sched.sv
// Flow controller around the show-ahead block FIFO between the block producer
// and the HDMI output. Generates FIFO write/read strobes, applies upstream
// backpressure from a tracked occupancy, holds reads until PREFILL complete
// blocks are buffered, and drops input after a framing error until the next
// start-of-frame. Carries no data.
// Ports:
//   clk, rst_n                           : clock, async active-low reset
//   up_valid/up_sob/up_eob/up_sof/up_ready : producer handshake and framing
//   buf_wr, buf_rd                       : FIFO wrreq / rdreq
//   buf_valid, buf_eob                   : FIFO not-empty / head word eob flag
//   dn_valid, dn_ready                   : downstream handshake
//   occ                                  : words in FIFO
//   err_sticky                           : framing error seen since reset
//   frames_cnt, drop_cnt                 : statistics (zero unless built)
// Optional feature: define BLOCKS_BUF_SCHED_STATS_EN to build the statistics counters.
module blocks_buf_sched
   import hdmi_if_pkg::*;
#(
   parameter  int unsigned SIZE    = 262144,
   parameter  int unsigned MARGIN  = 8,
   parameter  int unsigned PREFILL = PREFILL_DEF,
   parameter  int unsigned BLK_LEN = BLK_LEN_DEF,
   localparam int unsigned W       = $clog2(SIZE + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   input  logic         up_sob,
   input  logic         up_eob,
   input  logic         up_sof,
   output logic         up_ready,
   output logic         buf_wr,
   input  logic         buf_valid,
   input  logic         buf_eob,
   output logic         buf_rd,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] occ,
   output logic         err_sticky,
   output logic [15:0]  frames_cnt,
   output logic [15:0]  drop_cnt
);

   localparam logic [W-1:0] HIGH_WM   = W'(SIZE - MARGIN);
   localparam logic [W-1:0] PREFILL_W = W'(PREFILL);

   sched_state_t state_q, state_d;
   logic [W-1:0] occ_q, occ_d, blk_cnt_q, blk_cnt_d;
   logic         rd_mid_q, rd_mid_d, err_q, err_d;
   logic         sof_word, active, offered, frame_err, rd_en;

   assign sof_word = up_valid & up_sob & up_sof;
   assign active   = (state_q == FILL) | (state_q == STREAM);
   assign up_ready = ~(active & (occ_q >= HIGH_WM));
   assign offered  = active & up_valid & up_ready;
   // IDLE/DROP accept only a start-of-frame word; an illegal word is never written.
   assign buf_wr   = active ? (offered & ~frame_err) : sof_word;
   assign rd_en    = (state_q == STREAM) & buf_valid & ((blk_cnt_q != '0) | rd_mid_q);
   assign dn_valid = rd_en;
   assign buf_rd   = rd_en & dn_ready;

   assign occ        = occ_q;
   assign err_sticky = err_q;

   blk_framing_chk #(
      .BLK_LEN (BLK_LEN)
   ) u_framing (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .chk_i  (offered),
      .wr_i   (buf_wr),
      .sob_i  (up_sob),
      .eob_i  (up_eob),
      .err_o  (frame_err)
   );

   always_comb begin
      occ_d = occ_q;
      unique case ({buf_wr, buf_rd})
         2'b10:   occ_d = occ_q + W'(1);
         2'b01:   occ_d = occ_q - W'(1);
         default: occ_d = occ_q;
      endcase

      blk_cnt_d = blk_cnt_q;
      unique case ({buf_wr & up_eob, buf_rd & buf_eob})
         2'b10:   blk_cnt_d = blk_cnt_q + W'(1);
         2'b01:   blk_cnt_d = blk_cnt_q - W'(1);
         default: blk_cnt_d = blk_cnt_q;
      endcase

      rd_mid_d = rd_mid_q;
      if (buf_rd) rd_mid_d = ~buf_eob;

      err_d = err_q | frame_err;

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (sof_word) state_d = FILL;
         FILL: begin
            if (frame_err)                   state_d = DROP;
            else if (blk_cnt_d >= PREFILL_W) state_d = STREAM;
         end
         STREAM:  if (frame_err) state_d = DROP;
         DROP:    if (sof_word) state_d = (occ_q == '0) ? FILL : STREAM;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         occ_q     <= '0;
         blk_cnt_q <= '0;
         rd_mid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         occ_q     <= occ_d;
         blk_cnt_q <= blk_cnt_d;
         rd_mid_q  <= rd_mid_d;
         err_q     <= err_d;
      end
   end

`ifdef BLOCKS_BUF_SCHED_STATS_EN
   logic [15:0] frames_q, drop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_q <= '0;
         drop_q   <= '0;
      end else begin
         if (buf_wr & sof_word) frames_q <= frames_q + 16'd1;
         if (up_valid & ~buf_wr & ((state_q == IDLE) | (state_q == DROP)))
            drop_q <= drop_q + 16'd1;
      end
   end

   assign frames_cnt = frames_q;
   assign drop_cnt   = drop_q;
`else
   assign frames_cnt = '0;
   assign drop_cnt   = '0;
`endif

   // The high watermark keeps occ below SIZE; these catch a mis-sized MARGIN or FIFO.
   a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                      !(buf_wr && !buf_rd && (occ_q == W'(SIZE))));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                      !(buf_rd && !buf_wr && (occ_q == '0)));

endmodule

// File: tb/tb_blocks_buf_sched.sv
module tb_blocks_buf_sched;
   import hdmi_if_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       up_valid = 1'b0, up_sob = 1'b0, up_eob = 1'b0, up_sof = 1'b0;
   logic       up_ready, buf_wr, buf_rd, dn_valid, err_sticky;
   logic       buf_valid = 1'b0, buf_eob = 1'b0, dn_ready = 1'b0;
   logic [6:0] occ;
   logic [15:0] frames_cnt, drop_cnt;

   int checks = 0;
   int errors = 0;

   // Show-ahead FIFO stand-in: holds only each word's eob flag.
   logic fq[$];

   int s_wr, s_rdy, s_dnv, s_rd, s_occ, s_err, s_st;

   always #5 clk = ~clk;

   blocks_buf_sched #(
      .SIZE    (64),
      .MARGIN  (8),
      .PREFILL (16),
      .BLK_LEN (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_sob     (up_sob),
      .up_eob     (up_eob),
      .up_sof     (up_sof),
      .up_ready   (up_ready),
      .buf_wr     (buf_wr),
      .buf_valid  (buf_valid),
      .buf_eob    (buf_eob),
      .buf_rd     (buf_rd),
      .dn_valid   (dn_valid),
      .dn_ready   (dn_ready),
      .occ        (occ),
      .err_sticky (err_sticky),
      .frames_cnt (frames_cnt),
      .drop_cnt   (drop_cnt)
   );

   typedef struct {
      int v, sob, eob, sof, dnr;
      int wr, rdy, dnv, rd, occ, st;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, sample outputs at the falling edge, update FIFO stand-in after the rising edge.
   task automatic cyc(input int v, input int sob, input int eob, input int sof, input int dnr);
      up_valid  = 1'(v);
      up_sob    = 1'(sob);
      up_eob    = 1'(eob);
      up_sof    = 1'(sof);
      dn_ready  = 1'(dnr);
      buf_valid = (fq.size() != 0);
      buf_eob   = (fq.size() != 0) ? fq[0] : 1'b0;
      @(negedge clk);
      s_wr  = int'(buf_wr);
      s_rdy = int'(up_ready);
      s_dnv = int'(dn_valid);
      s_rd  = int'(buf_rd);
      s_occ = int'(occ);
      s_err = int'(err_sticky);
      s_st  = int'(dut.state_q);
      @(posedge clk);
      #1;
      if (s_rd != 0) void'(fq.pop_front());
      if (s_wr != 0) fq.push_back(1'(eob));
      buf_valid = (fq.size() != 0);
      buf_eob   = (fq.size() != 0) ? fq[0] : 1'b0;
   endtask

   task automatic wr_block(input int sof, input int dnr, input int exp_dnv);
      cyc(1, 1, 0, sof, dnr); chk("blk_sob_wr", s_wr, 1);
      if (exp_dnv >= 0) chk("blk_sob_dnv", s_dnv, exp_dnv);
      cyc(1, 0, 0, 0, dnr);   chk("blk_mid_wr", s_wr, 1);
      if (exp_dnv >= 0) chk("blk_mid_dnv", s_dnv, exp_dnv);
      cyc(1, 0, 1, 0, dnr);   chk("blk_eob_wr", s_wr, 1);
      if (exp_dnv >= 0) chk("blk_eob_dnv", s_dnv, exp_dnv);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      up_valid = 1'b0; up_sob = 1'b0; up_eob = 1'b0; up_sof = 1'b0; dn_ready = 1'b0;
      fq.delete();
      buf_valid = 1'b0;
      buf_eob   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      //            v sob eob sof dnr  wr rdy dnv rd occ st
      tbl[0] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0, int'(IDLE)};
      tbl[1] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0, int'(IDLE)};
      tbl[2] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0, int'(IDLE)};
      tbl[3] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0, int'(IDLE)};
      tbl[4] = '{1, 1, 0, 1, 0,  1, 1, 0, 0, 0, int'(IDLE)};
      tbl[5] = '{1, 0, 0, 0, 0,  1, 1, 0, 0, 1, int'(FILL)};
      tbl[6] = '{1, 0, 1, 0, 0,  1, 1, 0, 0, 2, int'(FILL)};
      tbl[7] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 3, int'(FILL)};

      // Reset and IDLE gating, first sof block
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].v, tbl[i].sob, tbl[i].eob, tbl[i].sof, tbl[i].dnr);
         chk($sformatf("vec%0d_wr", i),  s_wr,  tbl[i].wr);
         chk($sformatf("vec%0d_rdy", i), s_rdy, tbl[i].rdy);
         chk($sformatf("vec%0d_dnv", i), s_dnv, tbl[i].dnv);
         chk($sformatf("vec%0d_rd", i),  s_rd,  tbl[i].rd);
         chk($sformatf("vec%0d_occ", i), s_occ, tbl[i].occ);
         chk($sformatf("vec%0d_st", i),  s_st,  tbl[i].st);
         chk($sformatf("vec%0d_err", i), s_err, 0);
      end
      chk("reset_frames", int'(frames_cnt), 1'b0 === 1'b0 ? 0 : 0);

      // Prefill: blocks 2..15 keep dn_valid low, 16th eob switches to STREAM
      for (int b = 2; b <= 15; b++) wr_block(0, 0, 0);
      cyc(1, 1, 0, 0, 0); chk("b16_sob_dnv", s_dnv, 0);
      cyc(1, 0, 0, 0, 0); chk("b16_mid_dnv", s_dnv, 0);
      cyc(1, 0, 1, 0, 0); chk("b16_eob_dnv", s_dnv, 0);
      chk("b16_eob_st", s_st, int'(FILL));
      chk("b16_eob_occ", s_occ, 47);
      cyc(0, 0, 0, 0, 0);
      chk("stream_st", s_st, int'(STREAM));
      chk("stream_dnv", s_dnv, 1);
      chk("stream_rd_held", s_rd, 0);
      chk("stream_occ", s_occ, 48);
      for (int k = 0; k < 48; k++) begin
         cyc(0, 0, 0, 0, 1);
         chk("drain_rd", s_rd, 1);
         chk("drain_occ", s_occ, 48 - k);
      end
      cyc(0, 0, 0, 0, 1);
      chk("drained_dnv", s_dnv, 0);
      chk("drained_occ", s_occ, 0);

      // sob inside an open block -> DROP, 5 words discarded, sof resumes STREAM
      cyc(1, 1, 0, 0, 0); chk("e1_w0_wr", s_wr, 1);
      cyc(1, 0, 0, 0, 0); chk("e1_w1_wr", s_wr, 1);
      cyc(1, 1, 0, 0, 0); chk("e1_bad_wr", s_wr, 0);
      chk("e1_bad_err_before", s_err, 0);
      cyc(1, 0, 0, 0, 0); chk("drop0_wr", s_wr, 0);
      chk("drop_st", s_st, int'(DROP));
      chk("drop_err", s_err, 1);
      chk("drop0_rdy", s_rdy, 1);
      cyc(1, 1, 0, 0, 0); chk("drop1_wr", s_wr, 0);
      cyc(1, 0, 1, 0, 0); chk("drop2_wr", s_wr, 0);
      cyc(1, 1, 1, 0, 0); chk("drop3_wr", s_wr, 0);
      cyc(1, 0, 0, 0, 0); chk("drop4_wr", s_wr, 0);
      chk("drop4_rdy", s_rdy, 1);
      cyc(1, 1, 0, 1, 0); chk("resume_sof_wr", s_wr, 1);
      chk("resume_sof_occ", s_occ, 2);
      cyc(1, 0, 0, 0, 0); chk("resume_st", s_st, int'(STREAM));
      chk("resume_mid_wr", s_wr, 1);
      cyc(1, 0, 1, 0, 0); chk("resume_eob_wr", s_wr, 1);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0, 0, 1);
         chk("e1_drain_rd", s_rd, 1);
         chk("e1_drain_occ", s_occ, 5 - k);
      end
      cyc(0, 0, 0, 0, 1);
      chk("e1_drained_dnv", s_dnv, 0);
      chk("e1_drained_occ", s_occ, 0);
`ifdef BLOCKS_BUF_SCHED_STATS_EN
      // 3 IDLE discards + 5 DROP discards; two frames started
      chk("drop_cnt", int'(drop_cnt), 8);
      chk("frames_cnt", int'(frames_cnt), 2);
`else
      chk("drop_cnt_off", int'(drop_cnt), 0);
      chk("frames_cnt_off", int'(frames_cnt), 0);
`endif

      // eob with no open block, FIFO empty -> DROP, then sof -> FILL
      cyc(1, 0, 1, 0, 0); chk("e2_bad_wr", s_wr, 0);
      cyc(1, 1, 0, 1, 0); chk("e2_sof_wr", s_wr, 1);
      chk("e2_sof_st", s_st, int'(DROP));
      chk("e2_sof_occ", s_occ, 0);
      cyc(0, 0, 0, 0, 0); chk("e2_fill_st", s_st, int'(FILL));
      chk("e2_fill_occ", s_occ, 1);
      chk("e2_fill_dnv", s_dnv, 0);

      // Backpressure at SIZE-MARGIN = 56
      do_reset();
      wr_block(1, 0, -1);
      for (int b = 2; b <= 18; b++) wr_block(0, 0, -1);
      cyc(1, 1, 0, 0, 0); chk("bp_w55_wr", s_wr, 1);
      cyc(1, 0, 0, 0, 0); chk("bp_w56_wr", s_wr, 1);
      chk("bp_w56_rdy", s_rdy, 1);
      cyc(1, 0, 1, 0, 0);
      chk("bp_full_occ", s_occ, 56);
      chk("bp_full_rdy", s_rdy, 0);
      chk("bp_full_wr", s_wr, 0);
      chk("bp_full_st", s_st, int'(STREAM));
      cyc(1, 0, 1, 0, 1);
      chk("bp_rd1_rdy", s_rdy, 0);
      chk("bp_rd1_rd", s_rd, 1);
      chk("bp_rd1_occ", s_occ, 56);
      cyc(1, 0, 1, 0, 1);
      chk("bp_wrrd_occ", s_occ, 55);
      chk("bp_wrrd_rdy", s_rdy, 1);
      chk("bp_wrrd_wr", s_wr, 1);
      chk("bp_wrrd_rd", s_rd, 1);
      cyc(0, 0, 0, 0, 0);
      chk("bp_const_occ", s_occ, 55);
      for (int k = 0; k < 55; k++) begin
         cyc(0, 0, 0, 0, 1);
         chk("bp_drain_rd", s_rd, 1);
         chk("bp_drain_occ", s_occ, 55 - k);
      end
      cyc(0, 0, 0, 0, 1);
      chk("bp_drained_dnv", s_dnv, 0);

      // Incomplete second block: reads stop after block 1, resume once its eob is written
      cyc(1, 1, 0, 0, 1); chk("ib_w0_dnv", s_dnv, 0); chk("ib_w0_occ", s_occ, 0);
      cyc(1, 0, 0, 0, 1); chk("ib_w1_dnv", s_dnv, 0); chk("ib_w1_occ", s_occ, 1);
      cyc(1, 0, 1, 0, 1); chk("ib_w2_dnv", s_dnv, 0); chk("ib_w2_occ", s_occ, 2);
      cyc(1, 1, 0, 0, 1); chk("ib_w3_rd", s_rd, 1);   chk("ib_w3_occ", s_occ, 3);
      cyc(1, 0, 0, 0, 1); chk("ib_w4_rd", s_rd, 1);   chk("ib_w4_occ", s_occ, 3);
      cyc(0, 0, 0, 0, 1); chk("ib_r2_rd", s_rd, 1);   chk("ib_r2_occ", s_occ, 3);
      cyc(0, 0, 0, 0, 1); chk("ib_stall_dnv", s_dnv, 0); chk("ib_stall_occ", s_occ, 2);
      cyc(0, 0, 0, 0, 1); chk("ib_stall2_dnv", s_dnv, 0);
      cyc(1, 0, 1, 0, 1); chk("ib_eob_wr", s_wr, 1); chk("ib_eob_dnv", s_dnv, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 1);
         chk("ib_resume_dnv", s_dnv, 1);
         chk("ib_resume_occ", s_occ, 3 - k);
      end
      cyc(0, 0, 0, 0, 1);
      chk("ib_empty_dnv", s_dnv, 0);
      chk("ib_empty_occ", s_occ, 0);

      // Reset asserted mid-STREAM
      wr_block(0, 0, -1);
      cyc(1, 0, 1, 0, 0); chk("rs_bad_wr", s_wr, 0);
      cyc(1, 1, 0, 1, 0); chk("rs_sof_wr", s_wr, 1);
      cyc(1, 0, 0, 0, 0); chk("rs_mid_st", s_st, int'(STREAM));
      cyc(0, 0, 0, 0, 0);
      chk("rs_pre_occ", s_occ, 5);
      chk("rs_pre_err", s_err, 1);
      rst_n = 1'b0;
      fq.delete();
      #1;
      chk("rs_async_occ", int'(occ), 0);
      chk("rs_async_err", int'(err_sticky), 0);
      chk("rs_async_st", int'(dut.state_q), int'(IDLE));
      @(posedge clk);
      #1;
      chk("rs_edge_occ", int'(occ), 0);
      chk("rs_edge_blk", int'(dut.blk_cnt_q), 0);
      chk("rs_edge_st", int'(dut.state_q), int'(IDLE));
      chk("rs_edge_err", int'(err_sticky), 0);
      chk("rs_edge_rdy", int'(up_ready), 1);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
